// File: rtl/fpu_op_sequencer.sv
// Single-issue sequencer between the FP issue stage and the shared FPU ALU:
// latches operands, strobes the ALU for a per-op latency, captures the result and keeps sticky flags.
module fpu_op_sequencer #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cond,
  output logic        rsp_err,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [9:0]  alu_ctl,
  input  logic [31:0] alu_result,
  input  logic        alu_com_result,
  input  logic [5:0]  alu_flags,
  output logic [5:0]  sticky_flags,
  input  logic        flags_clr
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [3:0]       OP_MUL = 4'd2;
  localparam logic [3:0]       OP_DIV = 4'd3;
  localparam logic [3:0]       OP_BLT = 4'd7;
  localparam logic [3:0]       OP_BGT = 4'd9;
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_strobe;
  logic             r_branch;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic [31:0]      r_result;
  logic             r_cond;
  logic             r_err;
  logic [5:0]       r_sticky;

  logic             w_accept;
  logic             w_capture;
  logic             w_legal;
  logic             w_branch;
  logic [9:0]       w_strobe;
  logic [CNT_W-1:0] w_lat_ld;

  // Opcode decode: compare/branch ops also raise the COM strobe (bit 6).
  always_comb begin
    w_legal  = (req_op <= OP_BGT);
    w_branch = (req_op >= OP_BLT) && (req_op <= OP_BGT);
    w_strobe = w_legal ? (10'd1 << req_op) : '0;
    if (w_branch) w_strobe[6] = 1'b1;
    case (req_op)
      OP_MUL:  w_lat_ld = MUL_LD;
      OP_DIV:  w_lat_ld = DIV_LD;
      default: w_lat_ld = '0;
    endcase
  end

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_capture = (r_state == S_EXEC) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_legal ? S_EXEC : S_DONE;
      S_EXEC: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_DONE);
    alu_ctl   = (r_state == S_EXEC) ? r_strobe : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_strobe <= '0;
      r_branch <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
      r_cond   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_op1    <= req_a;
      r_op2    <= req_b;
      r_strobe <= w_strobe;
      r_branch <= w_branch;
      r_cnt    <= w_lat_ld;
      if (!w_legal) begin
        r_result <= '0;
        r_cond   <= 1'b0;
        r_err    <= 1'b1;
      end
    end else if (r_state == S_EXEC) begin
      if (r_cnt == '0) begin
        r_result <= alu_result;
        r_cond   <= r_branch & alu_com_result;
        r_err    <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // A clear coinciding with a capture keeps only the newly captured flags.
  always_ff @(posedge clk) begin
    if (reset)          r_sticky <= '0;
    else if (flags_clr) r_sticky <= w_capture ? alu_flags : '0;
    else if (w_capture) r_sticky <= r_sticky | alu_flags;
  end

  assign rsp_result   = r_result;
  assign rsp_cond     = r_cond;
  assign rsp_err      = r_err;
  assign alu_op1      = r_op1;
  assign alu_op2      = r_op2;
  assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer: a driver pushes expected responses, a negedge
// monitor checks strobes, latency and responses against a behavioural ALU/reference model.
module tb_fpu_op_sequencer;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_cond;
  logic        rsp_err;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [9:0]  alu_ctl;
  logic [31:0] alu_result;
  logic        alu_com_result;
  logic [5:0]  alu_flags = '0;
  logic [5:0]  sticky_flags;
  logic        flags_clr = 1'b0;

  fpu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cond(rsp_cond), .rsp_err(rsp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_com_result(alu_com_result), .alu_flags(alu_flags),
    .sticky_flags(sticky_flags), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cond;
    logic        err;
    logic [5:0]  sticky;
    logic [9:0]  ctl;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ctl_cnt = 0;
  bit          prev_valid = 1'b0;
  int          bp_mode = 0;
  logic [5:0]  sticky_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU driven purely by the strobes and operands the DUT presents.
  always_comb begin
    alu_result     = '0;
    alu_com_result = 1'b0;
    if      (alu_ctl[0]) alu_result = alu_op1 + alu_op2;
    else if (alu_ctl[1]) alu_result = alu_op1 - alu_op2;
    else if (alu_ctl[2]) alu_result = alu_op1 * alu_op2;
    else if (alu_ctl[3]) alu_result = (alu_op2 == 0) ? '1 : alu_op1 / alu_op2;
    else if (alu_ctl[4]) alu_result = ~alu_op1;
    else if (alu_ctl[5]) alu_result = {1'b0, alu_op1[30:0]};
    else if (alu_ctl[6]) alu_result = {29'd0, $signed(alu_op1) > $signed(alu_op2),
                                       alu_op1 == alu_op2, $signed(alu_op1) < $signed(alu_op2)};
    if      (alu_ctl[7]) alu_com_result = $signed(alu_op1) < $signed(alu_op2);
    else if (alu_ctl[8]) alu_com_result = alu_op1 == alu_op2;
    else if (alu_ctl[9]) alu_com_result = $signed(alu_op1) > $signed(alu_op2);
  end

  function automatic int op_lat(input logic [3:0] op);
    if (op > 4'd9)  return 0;
    if (op == 4'd2) return MUL_LAT;
    if (op == 4'd3) return DIV_LAT;
    return 1;
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd4: return ~a;
      4'd5: return a & 32'h7FFF_FFFF;
      4'd6, 4'd7, 4'd8, 4'd9:
        return {29'd0, $signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd7: return $signed(a) < $signed(b);
      4'd8: return a == b;
      4'd9: return $signed(a) > $signed(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        2:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      ctl_cnt    = 0;
      prev_valid = 1'b0;
    end else begin
      if (alu_ctl != '0) begin
        if (q.size() == 0) fail_event("alu_ctl_without_request");
        else begin
          check("alu_ctl", {22'd0, alu_ctl}, {22'd0, q[$].ctl});
          ctl_cnt++;
        end
      end
      if (rsp_valid && !prev_valid) begin
        if (q.size() == 0) fail_event("unexpected_rsp_valid");
        else begin
          check("rsp_latency", cyc, q[0].acc_cyc + q[0].lat);
          check("ctl_cycles", ctl_cnt, q[0].lat);
          ctl_cnt = 0;
        end
      end
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("rsp_result", rsp_result, e.res);
        check("rsp_cond", {31'd0, rsp_cond}, {31'd0, e.cond});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("sticky_flags", {26'd0, sticky_flags}, {26'd0, e.sticky});
        check("alu_op1", alu_op1, e.a);
        check("alu_op2", alu_op2, e.b);
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] fl, input bit clr_cap);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      fail_event("req_ready_timeout");
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    alu_flags = fl;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 4'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    e.a       = a;
    e.b       = b;
    e.lat     = op_lat(op);
    e.acc_cyc = cyc;
    e.err     = (op > 4'd9);
    e.res     = ref_result(op, a, b);
    e.cond    = ref_cond(op, a, b);
    e.ctl     = '0;
    if (!e.err) begin
      e.ctl[op] = 1'b1;
      if (op >= 4'd7) e.ctl[6] = 1'b1;
      sticky_m = clr_cap ? fl : (sticky_m | fl);
    end
    e.sticky = sticky_m;
    q.push_back(e);
    if (clr_cap && !e.err) begin
      repeat (e.lat - 1) begin @(posedge clk); #1; end
      flags_clr = 1'b1;
      @(posedge clk);
      #1;
      flags_clr = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) fail_event("drain_timeout");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_rsp_cond_err", {30'd0, rsp_cond, rsp_err}, 32'd0);
    check("reset_alu_ops", alu_op1 | alu_op2, 32'd0);
    check("reset_alu_ctl", {22'd0, alu_ctl}, 32'd0);
    check("reset_sticky", {26'd0, sticky_flags}, 32'd0);
    reset = 1'b0;

    issue(4'd0, 32'd3, 32'd4, 6'd0, 1'b0);
    drain();
    issue(4'd2, 32'd1234, 32'd77, 6'b001000, 1'b0);
    drain();

    // BEQ held in DONE by back-pressure
    bp_mode = 2;
    @(posedge clk);
    #1;
    issue(4'd8, 32'h3F80_0000, 32'h3F80_0000, 6'd0, 1'b0);
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      if (!rsp_valid) fail_event("beq_rsp_timeout");
      repeat (3) begin
        @(negedge clk);
        check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_rsp_result", rsp_result, 32'd2);
        check("hold_rsp_cond", {31'd0, rsp_cond}, 32'd1);
        check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
    end
    bp_mode = 0;
    @(posedge clk);
    #1;
    drain();

    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
    sticky_m  = '0;
    check("flags_clr_idle", {26'd0, sticky_flags}, 32'd0);
    issue(4'd3, 32'd100, 32'd0, 6'b000001, 1'b0);
    issue(4'd2, 32'hFFFF_0000, 32'h0001_0000, 6'b100000, 1'b0);
    drain();
    check("sticky_accum", {26'd0, sticky_flags}, 32'h21);
    issue(4'd0, 32'd5, 32'd6, 6'b001000, 1'b1);
    drain();
    check("sticky_clr_capture", {26'd0, sticky_flags}, 32'h08);

    issue(4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 6'h3F, 1'b0);
    drain();

    // DIV interrupted by reset in EXEC cycle 8
    issue(4'd3, 32'd999, 32'd3, 6'h3F, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_alu_ctl", {22'd0, alu_ctl}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_sticky", {26'd0, sticky_flags}, 32'd0);
    reset    = 1'b0;
    sticky_m = '0;
    repeat (25) begin @(posedge clk); #1; end

    bp_mode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  fl;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? (op == 4'd3 ? 32'd0 : a) : $urandom;
      fl = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      issue(op, a, b, fl, $urandom_range(0, 7) == 0);
    end
    drain();
    bp_mode = 0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
